// File: rtl/tlul_rsp_intg_chk.sv
// Minimal TL-UL D-channel types, followed by the host-side response integrity checker.
// The checker recomputes SECDED(64,57) check bits over the response header and reports mismatches.
package tlul_pkg;
  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_rsp_intg_chk #(
  parameter int CntW      = 8,
  parameter int Threshold = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_d2h_t tl_i,
  input  logic              d_ready_i,
  input  logic              clr_i,
  output logic              err_o,
  output logic [6:0]        syndrome_o,
  output logic [CntW-1:0]   err_cnt_o,
  output logic              fatal_o,
  output logic              alert_req_o,
  input  logic              alert_ack_i
);
  localparam logic [6:0][63:0] MASK = {
    64'h01FBDDA769A46910, 64'h01F7BB56D5525488, 64'h01EF76CDB2C93244,
    64'h01DEEE3B8E388E22, 64'h01BDE1F87E0781E1, 64'h017C1FF801FF801F,
    64'h0103FFF800007FFF
  };
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  logic [56:0]     w_p;
  logic [6:0]      w_chk, w_syn, w_syn_d;
  logic            w_fail, w_fatal_d, w_clr_pend_d;
  logic [CntW-1:0] w_cnt_base, w_cnt_d;
  logic            w_unused;
  state_e          r_state, w_state_d;
  logic            r_err, r_fatal, r_clr_pend;
  logic [6:0]      r_syn;
  logic [CntW-1:0] r_cnt;

  // Only the header fields are covered by rsp_intg; the rest of the channel is observed but ignored.
  assign w_unused = ^{tl_i.d_param, tl_i.d_source, tl_i.d_sink, tl_i.d_data,
                      tl_i.d_user.data_intg, tl_i.a_ready};

  assign w_p = {51'b0, tl_i.d_opcode, tl_i.d_size, tl_i.d_error};

  always_comb begin
    w_chk = '0;
    for (int k = 0; k < 7; k++) w_chk[k] = ^(w_p & MASK[k][56:0]);
  end

  assign w_syn  = w_chk ^ tl_i.d_user.rsp_intg;
  assign w_fail = tl_i.d_valid && d_ready_i && (w_syn != 7'h00);

  // A clear takes effect before a coincident failing beat is counted.
  assign w_cnt_base = clr_i ? '0 : r_cnt;
  assign w_cnt_d    = (w_fail && (w_cnt_base != CntMax)) ? w_cnt_base + 1'b1 : w_cnt_base;
  assign w_fatal_d  = (r_fatal && !clr_i) || (w_fail && (w_cnt_d >= CntW'(Threshold)));
  assign w_syn_d    = w_fail ? w_syn : (clr_i ? 7'h00 : r_syn);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err   <= 1'b0;
      r_syn   <= '0;
      r_cnt   <= '0;
      r_fatal <= 1'b0;
    end else begin
      r_err   <= w_fail;
      r_syn   <= w_syn_d;
      r_cnt   <= w_cnt_d;
      r_fatal <= w_fatal_d;
    end
  end

  // A clear seen during REQ is remembered so the handshake finishes straight back into IDLE.
  always_comb begin
    w_state_d    = r_state;
    w_clr_pend_d = r_clr_pend;
    case (r_state)
      IDLE: if (w_fatal_d) w_state_d = REQ;
      REQ: begin
        if (clr_i) w_clr_pend_d = 1'b1;
        if (alert_ack_i) begin
          w_state_d    = (r_clr_pend || clr_i) ? IDLE : DONE;
          w_clr_pend_d = 1'b0;
        end
      end
      DONE: if (clr_i) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_clr_pend <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_clr_pend <= w_clr_pend_d;
    end
  end

  assign err_o       = r_err;
  assign syndrome_o  = r_syn;
  assign err_cnt_o   = r_cnt;
  assign fatal_o     = r_fatal;
  assign alert_req_o = (r_state == REQ);
endmodule

// File: tb/tb_tlul_rsp_intg_chk.sv
// Bench for tlul_rsp_intg_chk: two instances (CntW=2/Threshold=3 and CntW=8/Threshold=1)
// share one stimulus stream; a scoreboard queue carries per-edge expectations to a monitor.
module tb_tlul_rsp_intg_chk;
  import tlul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  tl_d2h_t    tl;
  logic       d_ready, clr;
  logic [1:0] ack;

  logic       err_a, fatal_a, req_a, err_b, fatal_b, req_b;
  logic [6:0] syn_a, syn_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  tlul_rsp_intg_chk #(.CntW(2), .Threshold(3)) u_a (
    .clk_i(clk), .rst_i(rst), .tl_i(tl), .d_ready_i(d_ready), .clr_i(clr),
    .err_o(err_a), .syndrome_o(syn_a), .err_cnt_o(cnt_a), .fatal_o(fatal_a),
    .alert_req_o(req_a), .alert_ack_i(ack[0]));

  tlul_rsp_intg_chk #(.CntW(8), .Threshold(1)) u_b (
    .clk_i(clk), .rst_i(rst), .tl_i(tl), .d_ready_i(d_ready), .clr_i(clr),
    .err_o(err_b), .syndrome_o(syn_b), .err_cnt_o(cnt_b), .fatal_o(fatal_b),
    .alert_req_o(req_b), .alert_ack_i(ack[1]));

  typedef struct packed {
    bit       err;
    bit [6:0] syn;
    bit [7:0] cnt;
    bit       fatal;
    bit       req;
  } exp_t;

  typedef struct packed {
    exp_t b;
    exp_t a;
  } pair_t;

  pair_t q[$];
  int    n_chk = 0;
  int    n_err = 0;

  // Reference model state, one slot per instance.
  bit [63:0] M [7] = '{64'h0103FFF800007FFF, 64'h017C1FF801FF801F, 64'h01BDE1F87E0781E1,
                       64'h01DEEE3B8E388E22, 64'h01EF76CDB2C93244, 64'h01F7BB56D5525488,
                       64'h01FBDDA769A46910};
  int       CMAX [2] = '{3, 255};
  int       TH   [2] = '{3, 1};
  int       m_cnt [2];
  bit       m_err [2], m_fatal [2], m_req [2], m_done [2], m_cseen [2];
  bit [6:0] m_syn [2];

  function automatic bit [6:0] ecc(input bit [5:0] pl);
    bit [56:0] p;
    bit [6:0]  c;
    p = {51'b0, pl};
    c = '0;
    for (int k = 0; k < 7; k++)
      for (int j = 0; j < 57; j++)
        if (M[k][j] && p[j]) c[k] = ~c[k];
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_err[i] = 0; m_fatal[i] = 0; m_syn[i] = 0;
      m_req[i] = 0; m_done[i] = 0; m_cseen[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit fail, input bit [6:0] s, input bit c, input bit ak);
    if (c) begin m_cnt[i] = 0; m_fatal[i] = 0; m_syn[i] = 0; end
    if (fail) begin
      if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
      m_syn[i] = s;
      if (m_cnt[i] >= TH[i]) m_fatal[i] = 1;
    end
    m_err[i] = fail;
    if (m_req[i]) begin
      if (c) m_cseen[i] = 1;
      if (ak) begin
        m_req[i]   = 0;
        m_done[i]  = !m_cseen[i];
        m_cseen[i] = 0;
      end
    end else if (m_done[i]) begin
      if (c) m_done[i] = 0;
    end else if (m_fatal[i]) begin
      m_req[i] = 1;
    end
  endtask

  function automatic exp_t snap(input int i);
    exp_t e;
    e.err = m_err[i]; e.syn = m_syn[i]; e.cnt = 8'(m_cnt[i]);
    e.fatal = m_fatal[i]; e.req = m_req[i];
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cyc(input bit v, input bit [5:0] pl, input bit [6:0] intg,
                     input bit rdy, input bit c, input bit [1:0] ak);
    pair_t    e;
    bit [6:0] s;
    bit       fail;
    @(negedge clk);
    tl.d_valid = v;
    {tl.d_opcode, tl.d_size, tl.d_error} = pl;
    tl.d_user.rsp_intg  = intg;
    tl.d_user.data_intg = 7'($urandom());
    tl.d_data   = $urandom();
    tl.d_param  = 3'($urandom());
    tl.d_source = 8'($urandom());
    d_ready = rdy; clr = c; ack = ak;
    s = ecc(pl) ^ intg;
    fail = v && rdy && (s != 7'h00);
    for (int i = 0; i < 2; i++) model_step(i, fail, s, c, ak[i]);
    e.a = snap(0);
    e.b = snap(1);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit [1:0] ak);
    repeat (n) cyc(1'b0, 6'h00, 7'h00, 1'b1, 1'b0, ak);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic cmp(input string d, input exp_t e, input bit er, input bit [6:0] sy,
                     input bit [7:0] cn, input bit fa, input bit rq);
    chk({d, ".err_o"},       int'(er), int'(e.err));
    chk({d, ".syndrome_o"},  int'(sy), int'(e.syn));
    chk({d, ".err_cnt_o"},   int'(cn), int'(e.cnt));
    chk({d, ".fatal_o"},     int'(fa), int'(e.fatal));
    chk({d, ".alert_req_o"}, int'(rq), int'(e.req));
  endtask

  always @(posedge clk) begin
    pair_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("a", e.a, err_a, syn_a, {6'b0, cnt_a}, fatal_a, req_a);
      cmp("b", e.b, err_b, syn_b, cnt_b, fatal_b, req_b);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, ".a_err"},   int'(err_a),   0);
    chk({tag, ".a_syn"},   int'(syn_a),   0);
    chk({tag, ".a_cnt"},   int'(cnt_a),   0);
    chk({tag, ".a_fatal"}, int'(fatal_a), 0);
    chk({tag, ".a_req"},   int'(req_a),   0);
    chk({tag, ".b_cnt"},   int'(cnt_b),   0);
    chk({tag, ".b_fatal"}, int'(fatal_b), 0);
    chk({tag, ".b_req"},   int'(req_b),   0);
  endtask

  bit [5:0] r_pl;
  bit [6:0] r_in;
  int       wait_cnt;

  initial begin
    rst = 1'b1; tl = '0; d_ready = 1'b0; clr = 1'b0; ack = 2'b00;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Zero payload passes; d_error-only payload passes with 7'h07 and fails with 7'h00.
    cyc(1, 6'h00, 7'h00, 1, 0, 2'b00);
    cyc(1, 6'h01, 7'h07, 1, 0, 2'b00);
    cyc(1, 6'h01, 7'h00, 1, 0, 2'b00);
    post_edge();
    chk("derr_syndrome", int'(syn_a), 7'h07);
    chk("derr_cnt", int'(cnt_a), 1);
    chk("derr_pulse", int'(err_a), 1);

    // Unaccepted corrupt beat, then the same beat accepted.
    cyc(1, 6'h01, 7'h00, 0, 0, 2'b00);
    cyc(1, 6'h01, 7'h00, 1, 0, 2'b00);
    cyc(0, 6'h00, 7'h00, 1, 1, 2'b00);
    idle(2, 2'b10);

    // Three back-to-back failures on the Threshold=3 instance, long ack wait, saturation.
    repeat (3) cyc(1, 6'h2A, 7'h00, 1, 0, 2'b00);
    post_edge();
    chk("thr3_cnt", int'(cnt_a), 3);
    chk("thr3_req", int'(req_a), 1);
    idle(4, 2'b00);
    idle(1, 2'b11);
    idle(1, 2'b00);
    repeat (2) cyc(1, 6'h15, 7'h01, 1, 0, 2'b00);
    post_edge();
    chk("sat_cnt", int'(cnt_a), 3);
    chk("no_rereq", int'(req_a), 0);
    cyc(0, 6'h00, 7'h00, 1, 1, 2'b00);
    idle(2, 2'b11);

    // Ack already high when REQ is entered.
    repeat (3) cyc(1, 6'h3F, 7'h00, 1, 0, 2'b11);
    idle(2, 2'b11);
    cyc(0, 6'h00, 7'h00, 1, 1, 2'b00);

    // Clear coincident with a failing beat.
    repeat (2) cyc(1, 6'h08, 7'h00, 1, 0, 2'b11);
    cyc(1, 6'h08, 7'h00, 1, 1, 2'b11);
    post_edge();
    chk("clr_and_fail_cnt", int'(cnt_a), 1);
    cyc(0, 6'h00, 7'h00, 1, 1, 2'b11);
    idle(2, 2'b11);

    // Asynchronous reset in the middle of a pending request.
    repeat (3) cyc(1, 6'h11, 7'h00, 1, 0, 2'b00);
    @(posedge clk);
    #3;
    chk("pre_rst_req", int'(req_a), 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    tl.d_valid = 1'b0; clr = 1'b0; ack = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r_pl = 6'($urandom());
      r_in = ecc(r_pl);
      if ($urandom_range(0, 1) == 1) r_in = r_in ^ 7'($urandom_range(1, 127));
      cyc(bit'($urandom_range(0, 3) != 0), r_pl, r_in, bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 15) == 0),
          {bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0)});
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
